// File: rtl/square_seq_if.sv
// Request/response bundle for the sequential squarer: operand and start strobe in,
// full-width square and one-cycle finish pulse out.
interface square_seq_if #(
    parameter int BIT_WIDTH = 16
);
    logic                   start;
    logic [BIT_WIDTH-1:0]   x_in;
    logic [2*BIT_WIDTH-1:0] x_out;
    logic                   finish;

    modport master (
        output start,
        output x_in,
        input  x_out,
        input  finish
    );

    modport slave (
        input  start,
        input  x_in,
        output x_out,
        output finish
    );
endinterface

// File: rtl/square_seq.sv
// Sequential shift-add squarer: one partial product per clock, fixed BIT_WIDTH-cycle latency.
// Define SQUARE_EARLY_EXIT_EN to stop as soon as the remaining multiplier bits are all zero.
module square_seq #(
    parameter int BIT_WIDTH = 16
) (
    input logic         clk,
    input logic         rst_n,
    square_seq_if.slave bus
);
    localparam int PW    = 2 * BIT_WIDTH;
    localparam int CNT_W = $clog2(BIT_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_WIDTH - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PW-1:0]        acc;
    logic [PW-1:0]        mcand;
    logic [BIT_WIDTH-1:0] mplier;
    logic [CNT_W-1:0]     cnt;
    logic [PW-1:0]        x_out_r;
    logic                 finish_r;

    logic                 accept;
    logic                 step;
    logic                 last_iter;
    logic [PW-1:0]        acc_sum;
    logic [BIT_WIDTH-1:0] mplier_shr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = BUSY;
            BUSY: if (last_iter) state_nxt = IDLE;
        endcase
    end

    // The adder never needs a carry-out: (2^W-1)^2 fits in 2W bits.
    always_comb begin
        accept     = 1'b0;
        step       = 1'b0;
        last_iter  = 1'b0;
        mplier_shr = mplier >> 1;
        acc_sum    = acc + (mplier[0] ? mcand : '0);
        case (state)
            IDLE: accept = bus.start;
            BUSY: begin
                step = 1'b1;
`ifdef SQUARE_EARLY_EXIT_EN
                last_iter = (cnt == LAST_CNT) || (mplier_shr == '0);
`else
                last_iter = (cnt == LAST_CNT);
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            x_out_r  <= '0;
            finish_r <= 1'b0;
        end else begin
            finish_r <= 1'b0;
            if (accept) begin
                acc    <= '0;
                mcand  <= {{BIT_WIDTH{1'b0}}, bus.x_in};
                mplier <= bus.x_in;
                cnt    <= '0;
            end else if (step) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier_shr;
                cnt    <= cnt + 1'b1;
                if (last_iter) begin
                    x_out_r  <= acc_sum;
                    finish_r <= 1'b1;
                end
            end
        end
    end

    assign bus.x_out  = x_out_r;
    assign bus.finish = finish_r;
endmodule

// File: tb/tb_square_seq.sv
// Scoreboard bench for square_seq: the driver predicts result and completion edge for every
// accepted request; an edge-synchronous monitor checks finish and x_out on every cycle.
module tb_square_seq;
    localparam int BW = 16;

    typedef struct {
        logic [BW-1:0]   x;
        logic [2*BW-1:0] val;
        int              due;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;

    square_seq_if #(.BIT_WIDTH(BW)) bus ();

    square_seq #(.BIT_WIDTH(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    sb_t             sb[$];
    int              edge_no   = 0;
    int              next_free = 0;
    int              n_checks  = 0;
    int              n_pass    = 0;
    logic            armed     = 1'b0;
    logic            rst_seen;
    logic [2*BW-1:0] model_out = '0;

    function automatic logic [2*BW-1:0] sq(input logic [BW-1:0] x);
        logic [63:0] p;
        p = 64'(x) * 64'(x);
        return p[2*BW-1:0];
    endfunction

    // Cycles from accept to completion edge.
    function automatic int exp_lat(input logic [BW-1:0] x);
        int n;
        n = BW;
`ifdef SQUARE_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < BW; i++) if (x[i]) n = i + 1;
`endif
        return n;
    endfunction

    function automatic logic [BW-1:0] isqrt(input logic [2*BW-1:0] v);
        longint unsigned r;
        longint unsigned t;
        r = 0;
        for (int b = BW - 1; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= 64'(v)) r = t;
        end
        return r[BW-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_no);
    endtask

    always @(posedge clk) begin
        sb_t e;
        edge_no++;
        rst_seen = !rst_n;
        #1;
        if (rst_seen) begin
            sb.delete();
            model_out = '0;
            armed     = 1'b1;
            check("reset_x_out", bus.x_out, 0);
            check("reset_finish", bus.finish, 0);
        end else if (armed) begin
            if (sb.size() > 0 && sb[0].due == edge_no) begin
                e = sb.pop_front();
                check("finish_pulse", bus.finish, 1);
                check("x_out_square", bus.x_out, e.val);
                check("sqrt_roundtrip", isqrt(bus.x_out), e.x);
                model_out = e.val;
            end else begin
                check("finish_idle", bus.finish, 0);
                check("x_out_held", bus.x_out, model_out);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.x_in  = BW'($urandom);
        end
    endtask

    task automatic pulse(input logic [BW-1:0] x);
        sb_t ent;
        int  e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = x;
        e = edge_no + 1;
        if (e >= next_free) begin
            ent.x   = x;
            ent.val = sq(x);
            ent.due = e + exp_lat(x);
            sb.push_back(ent);
            next_free = ent.due + 1;
        end
    endtask

    // Returns one negedge before the first edge at which a new start is accepted.
    task automatic wait_free();
        int g;
        g = 0;
        while (edge_no + 2 < next_free && g < 200) begin
            idle(1);
            g++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        bus.start = 1'b0;
        next_free = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int gap;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.x_in  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        pulse(16'h0003); idle(1); wait_free();
        pulse(16'hFFFF); idle(1); wait_free();
        pulse(16'h0000); idle(1); wait_free();
        pulse(16'h8000); idle(1); wait_free();
        pulse(16'h0005); idle(1); wait_free();

        // Start while busy is dropped; start in the finish cycle is taken.
        pulse(16'd7); idle(4); pulse(16'd9); idle(1); wait_free();
        pulse(16'd9); idle(1); wait_free();

        pulse(16'd200); idle(7); do_reset();
        pulse(16'd200); idle(1); wait_free();

        repeat (1000) begin
            pulse(BW'($urandom));
            gap = $urandom_range(0, 3);
            if (gap == 0) begin
                idle(3);
                pulse(BW'($urandom));
            end
            idle(1);
            wait_free();
            idle(gap);
        end

        idle(BW + 4);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/square_seq.md
# square_seq

Sequential shift-add squarer, the inverse of the sequential square-root unit in the VGA pixel math path. It accepts an unsigned `BIT_WIDTH`-bit operand on a `start` pulse and computes one partial product per clock. It returns the full `2*BIT_WIDTH`-bit square with a one-cycle `finish` pulse. It feeds distance/intensity terms into the sqrt stage and lets the bench check `sqrt(square(x)) == x`.

## Interface
- `BIT_WIDTH`, default 16: operand width, unsigned; legal range 2..32.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request strobe; sampled only in IDLE.
- `x_in`  in  BIT_WIDTH  operand; sampled on the same edge as `start`.
- `x_out`  out  2*BIT_WIDTH  result `x_in*x_in`; registered and held until the next completion.
- `finish`  out  1  one-cycle completion pulse; `x_out` is valid while it is high and afterwards.

## Operation
- Internal state:
  - FSM {IDLE, BUSY}
  - `acc` of 2*BIT_WIDTH bits
  - `mcand` of 2*BIT_WIDTH bits
  - `mplier` of BIT_WIDTH bits
  - iteration counter `cnt` of clog2(BIT_WIDTH)+1 bits
- Reset, sampled with `rst_n`=0 on a rising edge:
  - FSM goes to IDLE.
  - `acc`, `mcand`, `mplier`, `cnt`, `x_out` and `finish` are cleared to 0.
  - Reset mid-operation aborts the computation. No `finish` is produced, and `x_out` reads 0.
- IDLE with `start`=1 (accept):
  - `mcand` <= zero-extended `x_in`; `mplier` <= `x_in`; `acc` <= 0; `cnt` <= 0.
  - FSM goes to BUSY.
- IDLE with `start`=0: state holds.
- BUSY, every cycle:
  - `acc` <= `acc` + (`mplier[0]` ? `mcand` : 0).
  - `mcand` <= `mcand` << 1.
  - `mplier` <= `mplier` >> 1.
  - `cnt` <= `cnt`+1.
- BUSY, last iteration (`cnt`==BIT_WIDTH-1, or the early-exit condition in Configuration):
  - `x_out` <= final accumulated value, including this cycle's add.
  - `finish` <= 1; FSM goes to IDLE.
- `finish` is cleared on every edge where it is not being set.
- Arithmetic: unsigned, no overflow possible. The maximum `(2^BIT_WIDTH-1)^2` fits in 2*BIT_WIDTH bits, so the adder needs no carry-out.
- `start` while BUSY is ignored. It is not queued, and the in-flight operand is unaffected.
- `start` in the cycle `finish`=1 is accepted, since the FSM is already IDLE. Back-to-back throughput is one result per BIT_WIDTH+1 cycles.
- `x_in` changes outside the accept edge have no effect.

## Timing
- Accept edge is E0. Iterations occur on edges E1..EN, with N = BIT_WIDTH by default.
- `finish` is high for exactly the one cycle following EN, so latency is N cycles from the accept edge.
- `x_out` updates on EN only and is stable at all other times.
- `x_out` is 0 out of reset until the first completion.
- BIT_WIDTH=16: `finish` goes high 16 cycles after the accept edge.

## Configuration
- `SQUARE_EARLY_EXIT_EN`
- Defined: an iteration is also the last when the shifted `mplier` becomes 0.
  - N = max(1, position of the highest set bit of `x_in` + 1).
  - `x_in`=0 completes in 1 cycle.
  - `x_out` values are identical to the fixed-latency build.
- Undefined: N = BIT_WIDTH for every operand. Latency is constant, as required by the fixed-schedule VGA pipeline.

## Test plan
- Reset, then `x_in`=16'h0003 with a 1-cycle `start` -> `finish` pulses once 16 cycles later; `x_out`=32'h0000_0009; `finish` is low on the next cycle.
- `x_in`=16'hFFFF -> `x_out`=32'hFFFE_0001.
- `x_in`=0 -> `x_out`=0:
  - without the macro after 16 cycles;
  - with `SQUARE_EARLY_EXIT_EN` after 1 cycle.
  - With the macro, `x_in`=16'h8000 takes 16 cycles and `x_in`=16'h0005 takes 3 cycles, giving `x_out`=25.
- `start` with `x_in`=7, then `start` with `x_in`=9 at cycle 5 -> only 49 is produced and the second request is dropped. A `start` with `x_in`=9 in the `finish` cycle is accepted and gives 81 after 16 more cycles.
- `rst_n`=0 at cycle 8 of a computation of 200 -> no `finish`; `x_out`=0. A new `start` with `x_in`=200 then gives 40000.
- Random sweep of 1000 operands -> each `x_out` equals `x_in^2`. Chaining into `sqrt_pipe` returns the original `x_in`.
